rr_mux_reg: RTL and testbench
=============================

Name: rr_mux_reg

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with a registered output and valid/ready handshakes.
- Supports round-robin arbitration or a forced fixed select, the latter matching the 2:1 selector muxes.
- Sits between producer stages (e.g. writeback sources, memory/ALU results) and a single consumer.
- Adds a one-cycle pipeline stage and back-pressure, which the combinational selector muxes do not have.

Parameters:
- WIDTH, 32, data width per channel, >=1.
- N, 4, number of input channels, >=2.
- SELW, $clog2(N), select/index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  N  per-channel data valid.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept strobe, combinational.
- force_en  input  1  1 = fixed-select mode, 0 = round-robin mode.
- force_sel  input  SELW  channel used when force_en=1.
- out_valid  output  1  registered output valid.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SELW  registered index of the channel that produced out_data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=N-1 so channel 0 has first priority. in_ready=0 while rst=1.
- Load condition: load = !out_valid || out_ready (single-stage pipeline with full throughput).
- Round-robin mode (force_en=0):
  - Search channels ptr+1, ptr+2, … modulo N (wrap from N-1 to 0).
  - Grant the first channel with in_valid=1; at most one grant per cycle.
- Forced mode (force_en=1):
  - grant = force_sel only if in_valid[force_sel]=1, otherwise no grant.
  - force_sel >= N yields no grant, never X.
  - Other channels are ignored, i.e. their in_ready=0.
- in_ready[i] = load && grant[i] && !rst. This is combinational and depends on out_ready.
- Transfer on clock edge with load=1 and a grant at index g:
  - out_valid<=1, out_data<=in_data[g], out_sel<=g.
  - Round-robin mode only: ptr<=g. Forced mode leaves ptr unchanged.
- Edge with load=1 and no grant: out_valid<=0; out_data/out_sel hold their previous values.
- Edge with load=0 (out_valid=1, out_ready=0): all outputs and ptr hold. out_data must stay stable while stalled.
- Simultaneous drain and refill (out_valid=1, out_ready=1, grant present): the new word replaces the old one in the same edge with no bubble.
- Mode switch mid-stream: takes effect on the next arbitration. A word already in the output register is unaffected.
- Reset asserted mid-transfer: outputs clear immediately (async). The held word is discarded; the producer sees no handshake.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 word/cycle when out_ready=1.
- No combinational path from in_data to out_data.

Test Plan:
- Reset/priority: N=4, WIDTH=32, after rst all in_valid=1 with data A0..A3, out_ready=1 → outputs over 4 cycles have out_sel 0,1,2,3 then 0 (wrap), out_data matching. Exactly one in_ready per cycle.
- Back-pressure: out_ready=0 after the first word 0xDEADBEEF is loaded; hold 5 cycles → out_valid=1, out_data=0xDEADBEEF stable, in_ready=0 throughout. Raise out_ready → next word is loaded the same edge with no bubble.
- Fairness with gaps: only channels 1 and 3 valid, out_ready=1 → out_sel alternates 1,3,1,3. Drop ch3 → ch1 every cycle.
- Forced mode: force_en=1, force_sel=2, all valid:
  - → out_sel=2 every cycle and in_ready=4'b0100.
  - in_valid[2]=0 → out_valid=0 next cycle.
  - Return to RR → arbitration resumes from the pointer held before forcing.
- 2:1 equivalence: N=2, WIDTH=5, force_en=1, force_sel toggling → out_data matches the selected channel, one cycle late.
- Async reset mid-stall: out_valid=1, out_ready=0, assert rst between clock edges → out_valid=0, out_data=0 before the next edge. After release, first grant goes to channel 0.

Source files
------------

// File: rtl/rr_mux_reg_if.sv
// Channel bundle for rr_mux_reg: N producer lanes, the mode/select controls
// and the single registered consumer lane.
interface rr_mux_reg_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               force_en;
  logic [SELW-1:0]    force_sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, force_en, force_sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, force_en, force_sel, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_reg.sv
// N-way round-robin / forced-select multiplexer with a single registered
// output stage and valid/ready back-pressure.
module rr_mux_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic         clk,
  input  logic         rst,
  rr_mux_reg_if.slave  bus
);
  localparam int SELW = $clog2(N);

  logic [SELW-1:0]  ptr_p0;
  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;
  logic [SELW-1:0]  sel_p0;

  logic             load;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  cand;
  logic [WIDTH-1:0] gnt_data;

  assign load = !vld_p0 || bus.out_ready;

  // Arbitration. Round-robin scans from farthest to nearest so the channel
  // closest after ptr_p0 is the last, and therefore winning, assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (bus.force_en) begin
      for (int i = 0; i < N; i++) begin
        if (bus.force_sel == SELW'(i) && bus.in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        cand = SELW'((int'(ptr_p0) + k) % N);
        if (bus.in_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i)) gnt_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.in_ready[i] = load && gnt_vld && (gnt_idx == SELW'(i)) && !rst;
    end
  end

  // Stage p0: output register and priority pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sel_p0  <= '0;
      ptr_p0  <= SELW'(N - 1);
    end else if (load) begin
      vld_p0 <= gnt_vld;
      if (gnt_vld) begin
        data_p0 <= gnt_data;
        sel_p0  <= gnt_idx;
        if (!bus.force_en) ptr_p0 <= gnt_idx;
      end
    end
  end

  assign bus.out_valid = vld_p0;
  assign bus.out_data  = data_p0;
  assign bus.out_sel   = sel_p0;
endmodule

// File: tb/tb_rr_mux_reg.sv
// Scoreboard bench for rr_mux_reg: a 4x32 instance under directed and random
// traffic, plus a 2x5 instance used as a forced 2:1 selector.
module tb_rr_mux_reg;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux_reg_if #(.WIDTH(32), .N(4)) b1 ();
  rr_mux_reg_if #(.WIDTH(5),  .N(2)) b2 ();

  rr_mux_reg #(.WIDTH(32), .N(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  rr_mux_reg #(.WIDTH(5),  .N(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct { logic [31:0] d; int s; } ent_t;

  int   tests = 0;
  int   fails = 0;
  ent_t q1[$];
  ent_t q2[$];
  int   prio[$] = '{0, 1, 2, 3};
  bit   m_vld  = 1'b0;
  bit   m2_vld = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference grant: priority list order in round-robin, fixed channel when forced.
  function automatic int mgrant(input logic [3:0] v, input logic fe, input logic [1:0] fs);
    if (fe) return (((v >> fs) & 4'd1) != 4'd0) ? int'(fs) : -1;
    for (int k = 0; k < prio.size(); k++)
      if (((v >> prio[k]) & 4'd1) != 4'd0) return prio[k];
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model1
    int g;
    if (rst) begin
      m_vld = 1'b0;
      prio  = '{0, 1, 2, 3};
      q1.delete();
    end else if (!m_vld || b1.out_ready) begin
      g = mgrant(b1.in_valid, b1.force_en, b1.force_sel);
      m_vld = (g >= 0);
      if (g >= 0) begin
        q1.push_back('{32'(b1.in_data >> (g * 32)), g});
        if (!b1.force_en)
          while (prio[3] != g) prio.push_back(prio.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon1
    int g;
    logic [3:0] eir;
    g   = mgrant(b1.in_valid, b1.force_en, b1.force_sel);
    eir = '0;
    if (!rst && (!m_vld || b1.out_ready) && g >= 0) eir = 4'd1 << g;
    chk("out_valid", 64'(b1.out_valid), 64'(m_vld));
    chk("in_ready", 64'(b1.in_ready), 64'(eir));
    if (b1.out_valid) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_empty: out_valid=1 with no expected word at %0t", $time);
      end else begin
        chk("out_data", 64'(b1.out_data), 64'(q1[0].d));
        chk("out_sel", 64'(b1.out_sel), 64'(q1[0].s));
        if (b1.out_ready) void'(q1.pop_front());
      end
    end
  end

  always @(posedge clk or posedge rst) begin : model2
    if (rst) begin
      m2_vld = 1'b0;
      q2.delete();
    end else begin
      m2_vld = b2.in_valid[b2.force_sel];
      if (m2_vld)
        q2.push_back('{32'(5'(b2.in_data >> (int'(b2.force_sel) * 5))), int'(b2.force_sel)});
    end
  end

  always @(negedge clk) begin : mon2
    logic [1:0] eir;
    eir = '0;
    if (!rst && b2.in_valid[b2.force_sel]) eir = 2'd1 << b2.force_sel;
    chk("sel2_valid", 64'(b2.out_valid), 64'(m2_vld));
    chk("sel2_ready", 64'(b2.in_ready), 64'(eir));
    if (b2.out_valid && q2.size() != 0) begin
      chk("sel2_data", 64'(b2.out_data), 64'(q2[0].d));
      chk("sel2_sel", 64'(b2.out_sel), 64'(q2[0].s));
      void'(q2.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    b2.in_valid  = 2'($urandom);
    b2.in_data   = 10'($urandom);
    b2.force_sel = ~b2.force_sel;
  endtask

  initial begin
    rst          = 1'b1;
    b1.in_valid  = '0;
    b1.in_data   = '0;
    b1.force_en  = 1'b0;
    b1.force_sel = '0;
    b1.out_ready = 1'b1;
    b2.in_valid  = '0;
    b2.in_data   = '0;
    b2.force_en  = 1'b1;
    b2.force_sel = '0;
    b2.out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_data", 64'(b1.out_data), 64'd0);
    chk("rst_sel", 64'(b1.out_sel), 64'd0);

    // All channels busy: priority starts at 0 and wraps
    b1.in_valid = 4'hF;
    b1.in_data  = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    repeat (6) tick();

    // Back-pressure hold
    b1.in_valid       = 4'h1;
    b1.in_data[31:0]  = 32'hDEAD_BEEF;
    tick();
    b1.out_ready = 1'b0;
    b1.in_valid  = 4'hF;
    b1.in_data[31:0] = 32'h1234_5678;
    repeat (5) begin
      tick();
      chk("stall_data", 64'(b1.out_data), 64'h0000_0000_DEAD_BEEF);
      chk("stall_valid", 64'(b1.out_valid), 64'd1);
    end
    b1.out_ready = 1'b1;
    tick();

    // Sparse requesters
    b1.in_valid = 4'b1010;
    repeat (6) tick();
    b1.in_valid = 4'b0010;
    repeat (3) tick();

    // Forced select, starved forced channel, then back to round-robin
    b1.in_valid  = 4'hF;
    b1.force_en  = 1'b1;
    b1.force_sel = 2'd2;
    repeat (4) tick();
    b1.in_valid = 4'b1011;
    repeat (2) tick();
    b1.in_valid = 4'hF;
    b1.force_en = 1'b0;
    repeat (4) tick();

    repeat (400) begin
      b1.in_valid  = 4'($urandom);
      b1.in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      b1.out_ready = (($urandom() % 4) != 0);
      b1.force_en  = (($urandom() % 5) == 0);
      b1.force_sel = 2'($urandom);
      tick();
    end

    // Async reset while stalled
    b1.force_en  = 1'b0;
    b1.in_valid  = 4'hF;
    b1.out_ready = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(b1.out_valid), 64'd0);
    chk("arst_data", 64'(b1.out_data), 64'd0);
    chk("arst_ready", 64'(b1.in_ready), 64'd0);
    tick();
    rst          = 1'b0;
    b1.out_ready = 1'b1;
    tick();
    chk("post_rst_sel", 64'(b1.out_sel), 64'd0);

    b1.in_valid = '0;
    repeat (3) tick();
    chk("drain", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
